// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e : arbiter FSM encoding
//   GNT_*       : values of the last_grant register
//   mem_req_t   : one memory access request (write flag, address, write data)
package dmem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    PER_BUSY = 2'd2
  } arb_state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_PER = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/lat_counter.sv
// Latency down-counter for the arbiter busy window.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load, load_val : load the counter (takes priority over decrement)
//   dec            : decrement by one, saturating at zero
//   zero_c         : combinational flag, counter is zero
module lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU MEM stage and a peripheral master.
// Each granted access holds mem_en/addr/data for MEM_LAT cycles; the CPU is
// frozen with cpu_stall until its own access reaches the done cycle.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   cpu_mem_read/write, cpu_addr/wdata: MEM-stage request (EX/MEM outputs)
//   cpu_rdata, cpu_stall              : combinational load data / pipeline freeze
//   per_req/we/addr/wdata             : peripheral request, held until per_ack
//   per_rdata, per_ack                : registered read data, one-cycle ack
//   mem_en/we/addr/wdata, mem_rdata   : memory port (rdata valid in done cycle)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              per_req,
  input  logic              per_we,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic [DATA_W-1:0] per_rdata,
  output logic              per_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Elaboration guard on the latency parameters.
  if ((MEM_LAT < 32'd1) || (MEM_LAT > 32'd15) || (MEM_LAT >= (32'd1 << CNT_W))) begin : g_bad_param
    $error("dmem_arbiter: MEM_LAT must be 1..15 and below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  arb_state_e state;
  logic       last_grant;

  logic       cpu_req_c;
  logic       cpu_wins_c;
  logic       per_wins_c;
  logic       cnt_zero_c;
  mem_req_t   win_c;

  assign cpu_req_c = cpu_mem_read | cpu_mem_write;

  // Round-robin: CPU wins unless the peripheral also asks and CPU went last.
  assign cpu_wins_c = (state == IDLE) && cpu_req_c &&
                      (!per_req || (last_grant == GNT_PER));
  assign per_wins_c = (state == IDLE) && !cpu_wins_c && per_req;

  // Winner's payload; a read+write CPU request is treated as a write.
  always_comb begin
    win_c = '{we: per_we, addr: per_addr, wdata: per_wdata};
    if (cpu_wins_c) begin
      win_c = '{we: cpu_mem_write, addr: cpu_addr, wdata: cpu_wdata};
    end
  end

  lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cpu_wins_c | per_wins_c),
    .load_val(LOAD_VAL),
    .dec     (state != IDLE),
    .zero_c  (cnt_zero_c)
  );

  // Arbiter FSM with registered memory-side and peripheral outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_PER;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      per_ack    <= 1'b0;
      per_rdata  <= '0;
    end else begin
      per_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_wins_c || per_wins_c) begin
            state      <= cpu_wins_c ? CPU_BUSY : PER_BUSY;
            last_grant <= cpu_wins_c ? GNT_CPU : GNT_PER;
            mem_en     <= 1'b1;
            mem_we     <= win_c.we;
            mem_addr   <= win_c.addr;
            mem_wdata  <= win_c.wdata;
          end
        end
        CPU_BUSY: begin
          if (cnt_zero_c) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        PER_BUSY: begin
          if (cnt_zero_c) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            per_rdata <= mem_rdata;
            per_ack   <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Stall drops only in the CPU done cycle so EX/MEM and MEM/WB can advance.
  assign cpu_stall = cpu_req_c & ~((state == CPU_BUSY) & cnt_zero_c);
  assign cpu_rdata = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between the CPU MEM stage and a peripheral bus master (UART loader / debug port).
- The MEM stage supplies its request from the EX/MEM pipeline register outputs: MemRead, MemWrite, ALUout as address, and the forwarded Rt value as write data.
- Sequences multi-cycle memory accesses (fixed latency MEM_LAT).
- Drives cpu_stall, which freezes PC, IF/ID, ID/EX and EX/MEM until the CPU access completes.

Parameters:
- MEM_LAT, 2, memory access latency in cycles. Legal range 1..15.
- CNT_W, 4, width of the latency counter. Must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mem_read  in  1  MEM-stage load request (MEM_MemRead).
- cpu_mem_write  in  1  MEM-stage store request (MEM_MemWrite).
- cpu_addr  in  32  MEM-stage byte address (MEM_ALUout).
- cpu_wdata  in  32  MEM-stage store data (MEM_MUX1).
- cpu_rdata  out  32  load data to MEM/WB; valid in the CPU completion cycle.
- cpu_stall  out  1  pipeline freeze.
- per_req  in  1  peripheral request; held high until per_ack.
- per_we  in  1  peripheral write enable.
- per_addr  in  32  peripheral address.
- per_wdata  in  32  peripheral write data.
- per_rdata  out  32  registered peripheral read data.
- per_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid in the final busy cycle.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- States:
  - IDLE.
  - CPU_BUSY.
  - PER_BUSY.
- Registers: state, cnt[CNT_W-1:0], last_grant (0 = CPU, 1 = PER).
- Reset values: state=IDLE, cnt=0, last_grant=PER, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, per_ack=0, per_rdata=0.
- cpu_req = cpu_mem_read | cpu_mem_write. If both are high, treat as a write.
- Arbitration in IDLE:
  - cpu_req and (!per_req or last_grant==PER): go to CPU_BUSY, last_grant<=CPU.
  - Otherwise, per_req: go to PER_BUSY, last_grant<=PER.
  - Result: round-robin when both request; a lone requester is always granted.
- On grant:
  - cnt<=MEM_LAT-1.
  - mem_en<=1.
  - mem_we<=winner's write flag.
  - mem_addr and mem_wdata <= winner's values.
  - These stay registered and stable for the whole busy window.
- Busy states:
  - cnt!=0: cnt decrements each cycle.
  - cnt==0 (done cycle): next state IDLE, mem_en<=0, mem_we<=0.
  - mem_addr and mem_wdata hold their last values after the access.
- CPU completion:
  - cpu_rdata = mem_rdata (combinational).
  - cpu_stall = cpu_req & !(state==CPU_BUSY & cnt==0) (combinational).
  - A CPU access stalls for exactly MEM_LAT cycles (grant cycle plus MEM_LAT-1 busy cycles); stall is low in the done cycle so EX/MEM and MEM/WB advance.
  - A CPU request also stalls while PER_BUSY, and while it loses arbitration in IDLE.
- Peripheral completion: in the PER_BUSY done cycle, per_rdata<=mem_rdata and per_ack<=1. per_ack is high only the following cycle.
- No CPU request: cpu_stall=0 regardless of peripheral activity.
- The requester sees no new grant in the cycle the FSM returns to IDLE; a new arbitration happens that IDLE cycle.
- Reset mid-access: the access is abandoned, no per_ack is issued, and mem_en=0 the cycle after reset.
- A write may be presented to memory for up to MEM_LAT cycles with the same addr/data; this is idempotent by design.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding IDLE=2'd0, CPU_BUSY=2'd1, PER_BUSY=2'd2.
  - grant constants GNT_CPU=1'b0, GNT_PER=1'b1.
- Sub-module lat_counter (load, decrement, zero flag, width CNT_W), instantiated once.

Test Plan:
- MEM_LAT=2, CPU lw at 0x10 (mem[0x10]=0xDEADBEEF) at c0 -> cpu_stall=1 at c0 and c1, 0 at c2; cpu_rdata=0xDEADBEEF at c2; mem_en=1 at c1 and c2.
- Peripheral write per_addr=0x20, per_wdata=0x00001234 at c0 -> mem_en and mem_we high at c1 and c2; per_ack pulse at c3 only; mem[0x20]=0x1234; cpu_stall=0 throughout.
- CPU sw and per_req both asserted at c0 after reset -> CPU granted first (last_grant=PER); peripheral granted at the next IDLE; a repeated simultaneous request then goes to the CPU again (alternation verified over 4 grants).
- CPU sw 0xCAFEF00D to 0x40, then lw from 0x40 -> load returns 0xCAFEF00D; each access stalls exactly MEM_LAT cycles.
- Reset asserted during PER_BUSY (cnt=1) -> state IDLE, mem_en=0 and per_ack=0 the next cycle; a subsequent request is served normally.
- MEM_LAT=1, back-to-back CPU loads -> cpu_stall alternates 1,0 per load; mem_en is one cycle per access.
